rsbus_r2d_inserter: RTL and testbench

//  Ring-side transmitter paired with the ring extractor: moves frames from a local TX FIFO onto the RS ring bus.

---
 rtl/rsbus_r2d_inserter.sv | 147 ++++++++++++++
 tb/tb_rsbus_r2d_inserter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsbus_r2d_inserter.sv
// RS ring inserter: watches slot headers and overwrites empty slots with complete frames
// from the local TX FIFO, keeping a fixed two-cycle ring latency.
module rsbus_r2d_inserter #(
  parameter int unsigned SLOT_WORDS  = 9,
  parameter int unsigned SHORT_WORDS = 2,
  parameter int unsigned LONG_WORDS  = 9,
  parameter bit          CLR_CTRL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sof,
  input  logic [11:0] i_ctrl,
  input  logic [71:0] i_bus,
  output logic        o_sof,
  output logic [11:0] o_ctrl,
  output logic [71:0] o_bus,
  input  logic        frm_i_rdy,
  input  logic        frm_i_len,
  output logic        frm_i_rd,
  input  logic [71:0] frm_i_bus,
  output logic        o_ins,
  output logic        o_err
);

  localparam int unsigned   CW      = $clog2(SLOT_WORDS + 1);
  localparam logic [CW-1:0] SHORT_N = CW'(SHORT_WORDS);
  localparam logic [CW-1:0] LONG_N  = CW'(LONG_WORDS);
  localparam logic [CW-1:0] ONE_N   = CW'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, INSERT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_q, n_d;
  logic          rd_d;
  logic          slot_free;

  logic          sof_q, rep_q, hdr_q;
  logic [11:0]   ctrl_q;
  logic [71:0]   bus_q;
  logic          o_sof_q, o_ins_q, o_err_q;
  logic [11:0]   o_ctrl_q, ctrl_mux;
  logic [71:0]   o_bus_q, bus_mux;

  // Inserted header is always marked busy and never as a recovery slot.
  function automatic logic [71:0] force_hdr(input logic [71:0] w);
    return {2'b10, w[69:0]};
  endfunction

  assign slot_free = i_sof & ~i_bus[71] & frm_i_rdy & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    rd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free) begin
          rd_d    = 1'b1;
          n_d     = frm_i_len ? LONG_N : SHORT_N;
          cnt_d   = ONE_N;
          state_d = INSERT;
        end else begin
          state_d = IDLE;
        end
      end
      INSERT: begin
        // Leave on the last read so the very next slot header can be claimed.
        if (cnt_q < n_q) begin
          rd_d  = 1'b1;
          cnt_d = cnt_q + ONE_N;
          if (cnt_d == n_q) begin
            state_d = IDLE;
          end else begin
            state_d = INSERT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign frm_i_rd = rd_d & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      n_q     <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  // FIFO data arrives one cycle after the read, lining up with the registered ring word.
  always_comb begin
    bus_mux  = bus_q;
    ctrl_mux = ctrl_q;
    if (rep_q) begin
      bus_mux  = hdr_q ? force_hdr(frm_i_bus) : frm_i_bus;
      ctrl_mux = CLR_CTRL ? 12'd0 : ctrl_q;
    end else begin
      bus_mux  = bus_q;
      ctrl_mux = ctrl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q    <= 1'b0;
      ctrl_q   <= 12'd0;
      bus_q    <= 72'd0;
      rep_q    <= 1'b0;
      hdr_q    <= 1'b0;
      o_sof_q  <= 1'b0;
      o_ctrl_q <= 12'd0;
      o_bus_q  <= 72'd0;
      o_ins_q  <= 1'b0;
      o_err_q  <= 1'b0;
    end else begin
      sof_q    <= i_sof;
      ctrl_q   <= i_ctrl;
      bus_q    <= i_bus;
      rep_q    <= rd_d;
      hdr_q    <= rd_d & (state_q == IDLE);
      o_sof_q  <= sof_q;
      o_ctrl_q <= ctrl_mux;
      o_bus_q  <= bus_mux;
      o_ins_q  <= hdr_q;
      o_err_q  <= i_sof & (state_q == INSERT);
    end
  end

  assign o_sof  = o_sof_q;
  assign o_ctrl = o_ctrl_q;
  assign o_bus  = o_bus_q;
  assign o_ins  = o_ins_q;
  assign o_err  = o_err_q;

endmodule

// File: tb/tb_rsbus_r2d_inserter.sv
// Bench for rsbus_r2d_inserter: directed vector table, multi-cycle corner sequences and
// randomized slots checked against a slot/frame-level reference model.
module tb_rsbus_r2d_inserter;
  localparam int LONG  = 9;
  localparam int SHORT = 2;
  localparam int MAXC  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sof = 1'b0;
  logic [11:0] i_ctrl = 12'd0;
  logic [71:0] i_bus = 72'd0;
  logic        o_sof;
  logic [11:0] o_ctrl;
  logic [71:0] o_bus;
  logic        frm_i_rdy = 1'b0;
  logic        frm_i_len = 1'b0;
  logic        frm_i_rd;
  logic [71:0] frm_i_bus = 72'd0;
  logic        o_ins;
  logic        o_err;

  always #5 clk = ~clk;

  rsbus_r2d_inserter dut (
    .clk(clk), .rst(rst), .i_sof(i_sof), .i_ctrl(i_ctrl), .i_bus(i_bus),
    .o_sof(o_sof), .o_ctrl(o_ctrl), .o_bus(o_bus),
    .frm_i_rdy(frm_i_rdy), .frm_i_len(frm_i_len), .frm_i_rd(frm_i_rd), .frm_i_bus(frm_i_bus),
    .o_ins(o_ins), .o_err(o_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rem = 0;
  int rd_cnt = 0;
  bit rd_prev = 1'b0;
  logic [71:0] fifo_q[$];
  logic [71:0] model_q[$];
  int          pend_len[$];
  int          ins_cyc[$];

  logic [71:0] bus_h[MAXC];
  logic [11:0] ctrl_h[MAXC];
  bit          sof_h[MAXC];
  bit          ins_h[MAXC];
  bit          err_h[MAXC];
  bit          rst_h[MAXC];

  typedef struct {
    bit sof; bit stb; bit reco; int push;
    bit e_rd; bit e_ins; bit e_err;
  } vec_t;
  vec_t tbl[21];

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  function automatic logic [11:0] rnd12();
    logic [31:0] t;
    t = $urandom;
    return t[11:0];
  endfunction

  function automatic logic [71:0] mk_bus(input bit stb, input bit reco);
    logic [71:0] w;
    w = rnd72();
    w[71] = stb;
    w[70] = reco;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_frame(input int n);
    logic [71:0] w;
    w = rnd72();
    w[39] = (n == LONG);
    fifo_q.push_back(w);
    model_q.push_back(w);
    for (int k = 1; k < n; k++) begin
      w = rnd72();
      fifo_q.push_back(w);
      model_q.push_back(w);
    end
    pend_len.push_back(n);
  endtask

  // One ring cycle: drive, evaluate the reference model, compare, account.
  task automatic step(input bit r, input bit sof, input logic [11:0] ctrl, input logic [71:0] bus);
    logic [71:0] eb, w, xb;
    logic [11:0] ec, xc;
    bit rd_m, hdr_m, err_m, sof_e, xs, xi, xe;
    if (cyc >= MAXC) begin
      n_fail++;
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    @(negedge clk);
    if (rd_prev) begin
      if (fifo_q.size() > 0) frm_i_bus = fifo_q.pop_front();
      else frm_i_bus = 72'd0;
    end
    rst = r; i_sof = sof; i_ctrl = ctrl; i_bus = bus;
    frm_i_rdy = (pend_len.size() > 0);
    frm_i_len = (pend_len.size() > 0) && (pend_len[0] == LONG);
    #1;
    rd_m = 1'b0; hdr_m = 1'b0; err_m = 1'b0;
    eb = bus; ec = ctrl; sof_e = sof;
    if (r) begin
      rem = 0; eb = 72'd0; ec = 12'd0; sof_e = 1'b0;
    end else begin
      if (rem > 0) begin
        rd_m = 1'b1; rem--; err_m = sof;
      end else if (sof && !bus[71] && pend_len.size() > 0) begin
        rem = pend_len.pop_front() - 1;
        rd_m = 1'b1; hdr_m = 1'b1;
      end
      if (rd_m) begin
        w = model_q.pop_front();
        eb = hdr_m ? {2'b10, w[69:0]} : w;
        ec = 12'd0;
      end
    end
    bus_h[cyc] = eb; ctrl_h[cyc] = ec; sof_h[cyc] = sof_e;
    ins_h[cyc] = hdr_m; err_h[cyc] = err_m; rst_h[cyc] = r;
    chk("rd", frm_i_rd, rd_m);
    if (cyc >= 1) begin
      if (rst_h[cyc-1] || cyc < 2) begin
        xb = 72'd0; xc = 12'd0; xs = 1'b0; xi = 1'b0;
      end else begin
        xb = bus_h[cyc-2]; xc = ctrl_h[cyc-2]; xs = sof_h[cyc-2]; xi = ins_h[cyc-2];
      end
      xe = rst_h[cyc-1] ? 1'b0 : err_h[cyc-1];
      chk("o_bus", o_bus, xb);
      chk("o_ctrl", o_ctrl, xc);
      chk("o_sof", o_sof, xs);
      chk("o_ins", o_ins, xi);
      chk("o_err", o_err, xe);
    end
    rd_prev = (frm_i_rd === 1'b1);
    if (rd_prev) rd_cnt++;
    if (o_ins === 1'b1) ins_cyc.push_back(cyc);
    if (r) begin
      fifo_q.delete(); model_q.delete(); pend_len.delete();
    end
    cyc++;
  endtask

  task automatic run_slot(input bit stb, input bit reco, input int inj);
    for (int w = 0; w < 9; w++) begin
      step(1'b0, (w == 0) || (w == inj), rnd12(), (w == 0) ? mk_bus(stb, reco) : rnd72());
    end
  endtask

  initial begin
    int rd0, i0, sp1, sp2;
    logic [11:0] kc;
    logic [71:0] kb;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, SHORT, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, LONG,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, SHORT, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0};

    step(1'b1, 1'b0, 12'd0, 72'd0);
    step(1'b1, 1'b0, 12'd0, 72'd0);

    // Short insert, full recovery slot skipped, long insert with stray sof, back-to-back short.
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].push != 0) push_frame(tbl[i].push);
      step(1'b0, tbl[i].sof, rnd12(), mk_bus(tbl[i].stb, tbl[i].reco));
      chk("tbl_rd", frm_i_rd, tbl[i].e_rd);
      chk("tbl_ins", o_ins, tbl[i].e_ins);
      chk("tbl_err", o_err, tbl[i].e_err);
    end

    // Empty FIFO: twenty mixed slots must pass through without any read.
    rd0 = rd_cnt;
    for (int s = 0; s < 20; s++) run_slot(s[0], s[1], -1);
    chk("t1_reads", rd_cnt - rd0, 0);

    // Three long frames into three consecutive empty slots.
    rd0 = rd_cnt;
    i0 = ins_cyc.size();
    for (int k = 0; k < 3; k++) push_frame(LONG);
    for (int s = 0; s < 3; s++) run_slot(1'b0, 1'b0, -1);
    step(1'b0, 1'b0, rnd12(), rnd72());
    step(1'b0, 1'b0, rnd12(), rnd72());
    chk("t4_reads", rd_cnt - rd0, 27);
    chk("t4_ins_cnt", ins_cyc.size() - i0, 3);
    sp1 = -1; sp2 = -1;
    if (ins_cyc.size() >= i0 + 3) begin
      sp1 = ins_cyc[i0+1] - ins_cyc[i0];
      sp2 = ins_cyc[i0+2] - ins_cyc[i0+1];
    end
    chk("t4_ins_gap1", sp1, 9);
    chk("t4_ins_gap2", sp2, 9);

    // Reset three reads into a long insert, then passthrough resumes.
    push_frame(LONG);
    step(1'b0, 1'b1, rnd12(), mk_bus(1'b0, 1'b0));
    step(1'b0, 1'b0, rnd12(), rnd72());
    step(1'b0, 1'b0, rnd12(), rnd72());
    step(1'b1, 1'b0, rnd12(), rnd72());
    chk("t6_rd_in_rst", frm_i_rd, 1'b0);
    kc = 12'h5A3;
    kb = 72'h80_1234_5678_9ABC_DEF0;
    step(1'b0, 1'b1, kc, kb);
    chk("t6_rd_after", frm_i_rd, 1'b0);
    chk("t6_bus_zero", o_bus, 72'd0);
    chk("t6_ctrl_zero", o_ctrl, 12'd0);
    chk("t6_sof_zero", o_sof, 1'b0);
    step(1'b0, 1'b0, rnd12(), rnd72());
    chk("t6_bus_zero2", o_bus, 72'd0);
    step(1'b0, 1'b0, rnd12(), rnd72());
    chk("t6_bus_lat2", o_bus, kb);
    chk("t6_ctrl_lat2", o_ctrl, kc);
    chk("t6_sof_lat2", o_sof, 1'b1);

    // Randomized slots, frames and stray headers.
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 2) == 0) push_frame(($urandom_range(0, 1) == 1) ? LONG : SHORT);
      run_slot($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1);
    end
    step(1'b0, 1'b0, rnd12(), rnd72());
    step(1'b0, 1'b0, rnd12(), rnd72());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
